// File: rtl/itof_pipe.sv
// itof_pipe: three-stage 32-bit integer to IEEE-754 single converter with valid/ready.
// Build option ITOF_RNE_EN selects round-to-nearest-even; without it results truncate toward zero.
module itof_pipe #(
  parameter int SIGNED = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  logic        en_s;
  logic        s0_s;
  logic [31:0] a0_s;
  logic [4:0]  lz1_s;
  logic        z1_s;
  logic [31:0] n_s;
  logic [7:0]  exp_s;
  logic        inc_s;
  logic [23:0] mant_s;
  logic [31:0] pk_s;
  logic        unused_s;

  logic        v1_r;
  logic        s1_r;
  logic [31:0] a1_r;
  logic        v2_r;
  logic        s2_r;
  logic        z2_r;
  logic [31:0] a2_r;
  logic [4:0]  lz2_r;
  logic        v3_r;
  logic [31:0] y3_r;

  // Position of the highest set bit counted from bit 31; a zero input is flagged separately.
  function automatic logic [4:0] lzc32(input logic [31:0] v);
    logic [4:0] cnt;
    cnt = 5'd31;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        cnt = 5'(31 - i);
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

  assign en_s      = ~v3_r | out_ready;
  assign in_ready  = en_s;
  assign out_valid = v3_r;
  assign y         = y3_r;

  // Sign extraction and magnitude; -0x80000000 wraps back to 0x80000000 as an unsigned value.
  always_comb begin
    s0_s = (SIGNED != 0) && x[31];
    if (s0_s) begin
      a0_s = ~x + 32'd1;
    end else begin
      a0_s = x;
    end
  end

  // Leading-zero count and zero detect on the registered magnitude.
  always_comb begin
    lz1_s = lzc32(a1_r);
    if (a1_r == 32'd0) begin
      z1_s = 1'b1;
    end else begin
      z1_s = 1'b0;
    end
  end

  // Normalize, round and pack; a mantissa carry-out bumps the exponent and leaves the fraction zero.
  always_comb begin
    n_s   = a2_r << lz2_r;
    exp_s = 8'd158 - {3'd0, lz2_r};
`ifdef ITOF_RNE_EN
    inc_s = n_s[7] & ((|n_s[6:0]) | n_s[8]);
`else
    inc_s = 1'b0;
`endif
    mant_s = {1'b0, n_s[30:8]} + {23'd0, inc_s};
    if (z2_r) begin
      pk_s = 32'd0;
    end else begin
      pk_s = {s2_r, exp_s + {7'd0, mant_s[23]}, mant_s[22:0]};
    end
  end

  // The implicit one and, in the truncating build, the round bits are intentionally dropped.
  assign unused_s = ^{n_s[31], n_s[7:0]};

  // Pipeline registers: every stage advances together on en, all hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r  <= 1'b0;
      s1_r  <= 1'b0;
      a1_r  <= 32'd0;
      v2_r  <= 1'b0;
      s2_r  <= 1'b0;
      z2_r  <= 1'b1;
      a2_r  <= 32'd0;
      lz2_r <= 5'd0;
      v3_r  <= 1'b0;
      y3_r  <= 32'd0;
    end else if (en_s) begin
      v1_r  <= in_valid & en_s;
      s1_r  <= s0_s;
      a1_r  <= a0_s;
      v2_r  <= v1_r;
      s2_r  <= s1_r;
      z2_r  <= z1_s;
      a2_r  <= a1_r;
      lz2_r <= lz1_s;
      v3_r  <= v2_r;
      y3_r  <= v2_r ? pk_s : 32'd0;
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: one signed and one unsigned instance driven in lockstep.
module tb_itof_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] x;
  logic        in_ready_s, out_valid_s, in_ready_u, out_valid_u;
  logic [31:0] y_s, y_u;

  always #5 clk = ~clk;

  itof_pipe #(.SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .x(x),
    .out_valid(out_valid_s), .out_ready(out_ready), .y(y_s)
  );

  itof_pipe #(.SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .x(x),
    .out_valid(out_valid_u), .out_ready(out_ready), .y(y_u)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] es;
    logic [31:0] eu;
  } vec_t;

  vec_t        tbl [10];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_out = 0;
  logic [31:0] q_s[$];
  logic [31:0] q_u[$];
  bit          stall_prev = 1'b0;
  logic [31:0] hold_s, hold_u;

  // Reference: exact integer value, then scale to 24 significant bits and round on the remainder.
  function automatic logic [31:0] ref_cvt(input logic [31:0] v, input bit sgn);
    longint unsigned m, q;
    int e, sh;
    bit neg;
`ifdef ITOF_RNE_EN
    longint unsigned rem, half;
`endif
    neg = sgn && v[31];
    m = {32'd0, v};
    if (neg) m = 64'h1_0000_0000 - m;
    if (m == 64'd0) return 32'd0;
    e = 0;
    while ((m >> (e + 1)) != 64'd0) e++;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh = e - 23;
      q = m >> sh;
`ifdef ITOF_RNE_EN
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
`endif
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {neg, 8'(e + 127), q[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic clear_sb();
    q_s.delete();
    q_u.delete();
    stall_prev = 1'b0;
  endtask

  // Sample 1 time unit after the inputs were driven on the falling edge; scoreboard the coming posedge.
  task automatic sample();
    #1;
    chk1("in_ready_s", in_ready_s, !(out_valid_s && !out_ready));
    chk1("in_ready_u", in_ready_u, !(out_valid_u && !out_ready));
    if (stall_prev) begin
      chk("stall_hold_s", y_s, hold_s);
      chk("stall_hold_u", y_u, hold_u);
      chk1("stall_valid", out_valid_s, 1'b1);
    end
    if (out_valid_s && out_ready) begin
      n_out++;
      if (q_s.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL extra_out_s: got %h, expected no output", y_s);
      end else begin
        chk("result_s", y_s, q_s.pop_front());
      end
    end
    if (out_valid_u && out_ready) begin
      if (q_u.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL extra_out_u: got %h, expected no output", y_u);
      end else begin
        chk("result_u", y_u, q_u.pop_front());
      end
    end
    if (in_valid && in_ready_s) begin
      q_s.push_back(ref_cvt(x, 1'b1));
      q_u.push_back(ref_cvt(x, 1'b0));
    end
    stall_prev = out_valid_s && !out_ready;
    hold_s = y_s;
    hold_u = y_u;
  endtask

  // Stream table entries back to back from an empty pipe and check the exact output cycle.
  task automatic run_tbl(input int lo, input int n);
    for (int c = 0; c < n + 3; c++) begin
      in_valid  = (c < n);
      x         = (c < n) ? tbl[lo + c].x : 32'd0;
      out_ready = 1'b1;
      sample();
      chk1($sformatf("lat_valid[%0d]", c), out_valid_s, (c >= 3));
      if (c >= 3) begin
        chk($sformatf("tbl_s[%0d]", lo + c - 3), y_s, tbl[lo + c - 3].es);
        chk($sformatf("tbl_u[%0d]", lo + c - 3), y_u, tbl[lo + c - 3].eu);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000};
`ifdef ITOF_RNE_EN
    tbl[1] = '{32'hFFFF_FFFF, 32'hBF80_0000, 32'h4F80_0000};
`else
    tbl[1] = '{32'hFFFF_FFFF, 32'hBF80_0000, 32'h4F7F_FFFF};
`endif
    tbl[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[3] = '{32'h8000_0000, 32'hCF00_0000, 32'h4F00_0000};
    tbl[4] = '{32'd16777217,  32'h4B80_0000, 32'h4B80_0000};
`ifdef ITOF_RNE_EN
    tbl[5] = '{32'd16777219,  32'h4B80_0002, 32'h4B80_0002};
    tbl[6] = '{32'h7FFF_FFFF, 32'h4F00_0000, 32'h4F00_0000};
`else
    tbl[5] = '{32'd16777219,  32'h4B80_0001, 32'h4B80_0001};
    tbl[6] = '{32'h7FFF_FFFF, 32'h4EFF_FFFF, 32'h4EFF_FFFF};
`endif
    tbl[7] = '{32'd5,         32'h40A0_0000, 32'h40A0_0000};
    tbl[8] = '{32'd10,        32'h4120_0000, 32'h4120_0000};
    tbl[9] = '{32'h00FF_FFFF, 32'h4B7F_FFFF, 32'h4B7F_FFFF};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sample();
    chk1("reset_in_ready", in_ready_s, 1'b1);
    chk1("reset_out_valid_s", out_valid_s, 1'b0);
    chk1("reset_out_valid_u", out_valid_u, 1'b0);
    chk("reset_y_s", y_s, 32'd0);
    chk("reset_y_u", y_u, 32'd0);
    @(negedge clk);

    run_tbl(0, 10);

    // Backpressure: 1..10 with a four-cycle consumer stall once results are flowing.
    begin
      int v, cyc, got0;
      v = 1; cyc = 0; got0 = n_out;
      while ((v <= 10 || (n_out - got0) < 10) && cyc < 80) begin
        in_valid  = (v <= 10);
        x         = v;
        out_ready = !(cyc >= 6 && cyc < 10);
        sample();
        if (in_valid && in_ready_s) v++;
        @(negedge clk);
        cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp_count", n_out - got0, 32'd10);
      chk("bp_queue_empty", q_s.size(), 32'd0);
    end

    // Reset with two operands in flight and a third being offered.
    in_valid = 1'b1; x = 32'd7;
    sample(); @(negedge clk);
    x = 32'd8;
    sample(); @(negedge clk);
    x = 32'd9;
    #2 rst = 1'b1;
    clear_sb();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk1("rst_out_valid_s", out_valid_s, 1'b0);
      chk1("rst_out_valid_u", out_valid_u, 1'b0);
      chk("rst_y_s", y_s, 32'd0);
      chk("rst_y_u", y_u, 32'd0);
      @(negedge clk);
    end
    run_tbl(7, 1);

    // Random regression with random handshakes on both sides.
    for (int i = 0; i < 30000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       x = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
        1:       x = 32'($urandom_range(0, 255));
        2:       x = 32'd0 - 32'($urandom_range(0, 255));
        3:       x = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        4:       x = $urandom >> $urandom_range(0, 31);
        default: x = $urandom;
      endcase
      sample();
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      @(negedge clk);
    end
    chk("drain_queue_s", q_s.size(), 32'd0);
    chk("drain_queue_u", q_u.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
